// File: rtl/pipe_pkg.sv
// Shared pipeline types for the fetch->decode boundary.
//   if_id_bundle_t : packed {instr, pc, pc_plus_4} carried between fetch and decode
//   skid_state_t   : occupancy of a 2-entry skid buffer
//   NOP_INSTR      : addi x0,x0,0, used as the bubble instruction
//   bubble_if_id() : builds the bundle driven while no item is presented
package pipe_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus_4;
   } if_id_bundle_t;

   // EMPTY: main invalid; FULL: main valid, skid invalid; SKID: both valid
   typedef enum logic [1:0] {
      SKB_EMPTY = 2'd0,
      SKB_FULL  = 2'd1,
      SKB_SKID  = 2'd2
   } skid_state_t;

   function automatic if_id_bundle_t bubble_if_id(
      input logic [XLEN-1:0] nop       = NOP_INSTR,
      input logic [XLEN-1:0] bubble_pc = '0
   );
      if_id_bundle_t b;
      b.instr     = nop;
      b.pc        = bubble_pc;
      b.pc_plus_4 = bubble_pc;
      return b;
   endfunction

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer with registered in_ready.
//   clk, rst        : clock, synchronous active-high reset
//   clear           : drop both entries (and anything accepted this cycle)
//   in_valid/ready  : upstream handshake; in_ready comes from a flop
//   in_data         : WIDTH-bit payload
//   out_valid/ready : downstream handshake
//   out_data        : payload of the oldest entry (held while stalled)
module pipe_skid_buffer
   import pipe_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   skid_state_t      state_q, state_d;
   logic             rdy_q;
   logic [WIDTH-1:0] main_q, skid_q;
   logic             ld_main_in, ld_main_skid, ld_skid;
   logic             accept, fire;

   // rdy_q already equals "not SKID"; the rst gate keeps in_ready low
   // for the whole reset cycle regardless of the pre-reset flop value.
   assign in_ready  = rdy_q & ~rst;
   assign out_valid = (state_q != SKB_EMPTY);
   assign out_data  = main_q;
   assign accept    = in_valid & in_ready;
   assign fire      = out_valid & out_ready;

   always_comb begin
      state_d      = state_q;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      unique case (state_q)
         SKB_EMPTY: begin
            if (accept) begin
               state_d    = SKB_FULL;
               ld_main_in = 1'b1;
            end
         end
         SKB_FULL: begin
            if (accept && fire) begin
               ld_main_in = 1'b1;
            end else if (accept) begin
               state_d = SKB_SKID;
               ld_skid = 1'b1;
            end else if (fire) begin
               state_d = SKB_EMPTY;
            end
         end
         SKB_SKID: begin
            if (fire) begin
               state_d      = SKB_FULL;
               ld_main_skid = 1'b1;
            end
         end
         default: state_d = SKB_EMPTY;
      endcase
      if (clear) begin
         state_d      = SKB_EMPTY;
         ld_main_in   = 1'b0;
         ld_main_skid = 1'b0;
         ld_skid      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SKB_EMPTY;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         rdy_q   <= (state_d != SKB_SKID);
      end
   end

   // Payload storage is qualified by state, so it carries no reset.
   always_ff @(posedge clk) begin
      if (ld_main_in)
         main_q <= in_data;
      else if (ld_main_skid)
         main_q <= skid_q;
      if (ld_skid)
         skid_q <= in_data;
   end

endmodule

// File: rtl/if_id_skid_stage.sv
// Fetch->decode pipeline register built on a 2-entry skid buffer.
//   clk, rst                     : clock, synchronous active-high reset
//   flush                        : discard everything held or arriving this cycle
//   in_valid/in_ready            : fetch handshake (in_ready registered)
//   in_instr/in_pc/in_pc_plus_4  : fetched item
//   out_valid/out_ready          : decode handshake
//   out_instr/out_pc/out_pc_plus_4 : presented item, bubble when !out_valid
//   stall_cnt                    : saturating count of out_valid && !out_ready cycles
module if_id_skid_stage
   import pipe_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    CNT_WIDTH  = 16,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = pipe_pkg::NOP_INSTR,
   parameter logic [DATA_WIDTH-1:0] BUBBLE_PC  = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_instr,
   input  logic [DATA_WIDTH-1:0] in_pc,
   input  logic [DATA_WIDTH-1:0] in_pc_plus_4,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_instr,
   output logic [DATA_WIDTH-1:0] out_pc,
   output logic [DATA_WIDTH-1:0] out_pc_plus_4,
   output logic [CNT_WIDTH-1:0]  stall_cnt
);

   localparam if_id_bundle_t BUBBLE = bubble_if_id(NOP_INSTR, BUBBLE_PC);
   localparam int            BUS_W  = $bits(if_id_bundle_t);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   if_id_bundle_t        in_bus, held_bus, out_bus;
   logic [BUS_W-1:0]     held_raw;
   logic [CNT_WIDTH-1:0] stall_q;

   assign in_bus.instr     = in_instr;
   assign in_bus.pc        = in_pc;
   assign in_bus.pc_plus_4 = in_pc_plus_4;

   pipe_skid_buffer #(
      .WIDTH (BUS_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_bus),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (held_raw)
   );

   // Stale storage is masked so decode always sees a clean bubble.
   assign held_bus      = if_id_bundle_t'(held_raw);
   assign out_bus       = out_valid ? held_bus : BUBBLE;
   assign out_instr     = out_bus.instr;
   assign out_pc        = out_bus.pc;
   assign out_pc_plus_4 = out_bus.pc_plus_4;

   // Flush does not clear the counter; only rst does.
   always_ff @(posedge clk) begin
      if (rst)
         stall_q <= '0;
      else if (out_valid && !out_ready && (stall_q != '1))
         stall_q <= stall_q + CNT_ONE;
   end

   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_if_id_skid_stage.sv
module tb_if_id_skid_stage;

   localparam int CW      = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   in_instr = '0;
   logic [31:0]   in_pc = '0;
   logic [31:0]   in_pc_plus_4 = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [31:0]   out_instr;
   logic [31:0]   out_pc;
   logic [31:0]   out_pc_plus_4;
   logic [CW-1:0] stall_cnt;

   if_id_skid_stage #(
      .DATA_WIDTH (32),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_instr      (in_instr),
      .in_pc         (in_pc),
      .in_pc_plus_4  (in_pc_plus_4),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_instr     (out_instr),
      .out_pc        (out_pc),
      .out_pc_plus_4 (out_pc_plus_4),
      .stall_cnt     (stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pp4;
   } item_t;

   // Reference: an ordered queue of at most two items plus a registered ready.
   item_t q[$];
   logic  rdy_m = 1'b1;
   int    cnt_m = 0;
   int    n_checks = 0;
   int    n_errors = 0;
   logic  seen_200 = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic f, input logic iv,
                       input logic [31:0] ins, input logic [31:0] pcv, input logic ordy);
      item_t head;
      logic  acc, fire;
      @(negedge clk);
      rst          = r;
      flush        = f;
      in_valid     = iv;
      in_instr     = ins;
      in_pc        = pcv;
      in_pc_plus_4 = pcv + 32'd4;
      out_ready    = ordy;
      #1;
      if (q.size() > 0) head = q[0];
      else begin
         head.instr = 32'h0000_0013;
         head.pc    = '0;
         head.pp4   = '0;
      end
      check_val("out_valid", 64'(out_valid), 64'(q.size() > 0));
      check_val("in_ready", 64'(in_ready), 64'(rdy_m && !r));
      check_val("out_instr", 64'(out_instr), 64'(head.instr));
      check_val("out_pc", 64'(out_pc), 64'(head.pc));
      check_val("out_pc_plus_4", 64'(out_pc_plus_4), 64'(head.pp4));
      check_val("stall_cnt", 64'(stall_cnt), 64'(cnt_m));
      if (out_valid === 1'b1 && out_pc === 32'h200) seen_200 = 1'b1;
      acc  = iv && rdy_m && !r;
      fire = (q.size() > 0) && ordy;
      @(posedge clk);
      if (r) begin
         q.delete();
         cnt_m = 0;
         rdy_m = 1'b1;
      end else begin
         if (q.size() > 0 && !ordy && cnt_m < CNT_MAX) cnt_m++;
         if (f) q.delete();
         else begin
            if (fire) void'(q.pop_front());
            if (acc) begin
               item_t it;
               it.instr = ins;
               it.pc    = pcv;
               it.pp4   = pcv + 32'd4;
               q.push_back(it);
            end
         end
         rdy_m = (q.size() < 2);
      end
   endtask

   initial begin
      // Let reset settle the design before the reference starts tracking it.
      repeat (2) @(posedge clk);
      step(1, 0, 0, 32'h0, 32'h0, 0);

      // Reset then idle
      step(0, 0, 0, 32'h0, 32'h0, 0);
      step(0, 0, 0, 32'h0, 32'h0, 1);

      // Streaming at full rate
      step(0, 0, 1, 32'h1111_0001, 32'h0, 1);
      step(0, 0, 1, 32'h1111_0002, 32'h4, 1);
      step(0, 0, 1, 32'h1111_0003, 32'h8, 1);
      step(0, 0, 0, 32'h0, 32'h0, 1);
      step(0, 0, 0, 32'h0, 32'h0, 1);

      // Back-pressure fills the skid entry, then drains in order
      step(0, 0, 1, 32'h2222_0001, 32'h100, 0);
      step(0, 0, 1, 32'h2222_0002, 32'h104, 0);
      step(0, 0, 1, 32'h2222_0003, 32'h108, 0);
      step(0, 0, 0, 32'h0, 32'h0, 0);
      step(0, 0, 0, 32'h0, 32'h0, 1);
      step(0, 0, 0, 32'h0, 32'h0, 1);
      step(0, 0, 0, 32'h0, 32'h0, 1);

      // Flush in SKID with a simultaneous offer
      step(0, 0, 1, 32'h3333_0001, 32'h180, 0);
      step(0, 0, 1, 32'h3333_0002, 32'h184, 0);
      seen_200 = 1'b0;
      step(0, 1, 1, 32'h3333_0003, 32'h200, 0);
      #1;
      check_val("flush_out_valid", 64'(out_valid), 64'd0);
      check_val("flush_out_instr", 64'(out_instr), 64'h13);
      check_val("flush_in_ready", 64'(in_ready), 64'd1);
      step(0, 0, 0, 32'h0, 32'h0, 1);
      step(0, 0, 0, 32'h0, 32'h0, 1);
      check_val("flush_no_0x200", 64'(seen_200), 64'd0);

      // Counter saturation
      step(0, 0, 1, 32'h4444_0001, 32'h300, 0);
      for (int i = 0; i < 20; i++) step(0, 0, 0, 32'h0, 32'h0, 0);
      #1;
      check_val("stall_sat", 64'(stall_cnt), 64'hF);

      // Reset wins over flush mid-SKID
      step(0, 0, 1, 32'h5555_0001, 32'h304, 0);
      step(1, 1, 1, 32'h5555_0002, 32'h500, 0);
      #1;
      check_val("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      check_val("rst_out_valid", 64'(out_valid), 64'd0);
      step(0, 0, 0, 32'h0, 32'h0, 1);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic        r, f, iv, ordy;
         logic [31:0] pcv;
         r    = ($urandom_range(99) < 2);
         f    = ($urandom_range(99) < 5);
         iv   = ($urandom_range(99) < 70);
         ordy = ($urandom_range(99) < 55);
         pcv  = {$urandom_range(32'h3FFF_FFFF), 2'b00};
         step(r, f, iv, $urandom, pcv, ordy);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
